key_entry: RTL and testbench

KEY_ENTRY -- requirements
Module: key_entry

---
 rtl/key_entry.sv | 102 ++++++++++
 tb/tb_key_entry.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// Keypad entry buffer: collects up to four BCD digits with backspace, clear and enter,
// and ignores further presses for LOCKOUT_TICKS cycles after each accepted press.
module key_entry #(
    parameter int LOCKOUT_TICKS = 5000000,
    parameter int MAX_DIGITS    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key,
    input  logic        key_pressed,
    output logic [15:0] value,
    output logic [2:0]  count,
    output logic        full,
    output logic        busy,
    output logic        entered,
    output logic [15:0] entered_value
);

    localparam int CNT_W = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;

    typedef enum logic {IDLE, LOCKOUT} state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_BACK  = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    state_t           state;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             is_digit;
    logic             key_valid;

    // Reset asserts immediately but releases two clock edges later, in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];
    assign is_digit  = (key <= 4'd9);
    assign key_valid = is_digit || (key == KEY_CLEAR) || (key == KEY_BACK) || (key == KEY_ENTER);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state         <= IDLE;
            lock_cnt      <= '0;
            value         <= '0;
            count         <= '0;
            full          <= 1'b0;
            busy          <= 1'b0;
            entered       <= 1'b0;
            entered_value <= '0;
        end else begin
            entered <= 1'b0;
            if (state == IDLE) begin
                if (key_pressed && key_valid) begin
                    state    <= LOCKOUT;
                    busy     <= 1'b1;
                    lock_cnt <= CNT_W'(LOCKOUT_TICKS - 1);
                    if (is_digit) begin
                        // A digit on a full buffer is swallowed but still debounced.
                        if (count < 3'(MAX_DIGITS)) begin
                            value <= {value[11:0], key};
                            count <= count + 3'd1;
                            full  <= (count == 3'(MAX_DIGITS - 1));
                        end
                    end else if (key == KEY_CLEAR) begin
                        value <= '0;
                        count <= '0;
                        full  <= 1'b0;
                    end else if (key == KEY_BACK) begin
                        if (count != 3'd0) begin
                            value <= {4'h0, value[15:4]};
                            count <= count - 3'd1;
                            full  <= 1'b0;
                        end
                    end else begin
                        if (count != 3'd0) begin
                            entered_value <= value;
                            entered       <= 1'b1;
                            value         <= '0;
                            count         <= '0;
                            full          <= 1'b0;
                        end
                    end
                end
            end else begin
                if (lock_cnt == '0) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    lock_cnt <= lock_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: a cycle-level reference model pushes expected outputs per edge
// into a queue, which is popped and compared after each edge; directed checks add spot values.
module tb_key_entry;

    localparam int T = 4;

    typedef struct packed {
        logic [15:0] value;
        logic [2:0]  count;
        logic        full;
        logic        busy;
        logic        entered;
        logic [15:0] entered_value;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key;
    logic        key_pressed;
    logic [15:0] value;
    logic [2:0]  count;
    logic        full;
    logic        busy;
    logic        entered;
    logic [15:0] entered_value;

    exp_t sb[$];
    int   total;
    int   bad;

    logic [15:0] m_value;
    logic [2:0]  m_count;
    logic [15:0] m_ev;
    logic        m_entered;
    int          m_left;

    key_entry #(.LOCKOUT_TICKS(T), .MAX_DIGITS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key(key),
        .key_pressed(key_pressed),
        .value(value),
        .count(count),
        .full(full),
        .busy(busy),
        .entered(entered),
        .entered_value(entered_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_value   = '0;
        m_count   = '0;
        m_ev      = '0;
        m_entered = 1'b0;
        m_left    = 0;
    endtask

    // One clock edge with the given inputs; model predicts, DUT is checked after the edge.
    task automatic step(input logic [3:0] k, input logic p);
        exp_t e;
        logic acc;
        key         = k;
        key_pressed = p;
        acc = p && (k <= 4'd9 || k == 4'hC || k == 4'hD || k == 4'hE) && (m_left == 0);
        m_entered = 1'b0;
        if (m_left > 0) m_left--;
        else if (acc) m_left = T;
        if (acc) begin
            if (k <= 4'd9) begin
                if (m_count < 3'd4) begin
                    m_value = {m_value[11:0], k};
                    m_count++;
                end
            end else if (k == 4'hC) begin
                m_value = '0;
                m_count = '0;
            end else if (k == 4'hD) begin
                if (m_count > 0) begin
                    m_value = m_value >> 4;
                    m_count--;
                end
            end else if (m_count > 0) begin
                m_ev      = m_value;
                m_entered = 1'b1;
                m_value   = '0;
                m_count   = '0;
            end
        end
        sb.push_back('{m_value, m_count, (m_count == 3'd4), (m_left > 0), m_entered, m_ev});
        @(posedge clk);
        #1;
        key_pressed = 1'b0;
        e = sb.pop_front();
        chk("sb_value", value, e.value);
        chk("sb_count", 16'(count), 16'(e.count));
        chk("sb_full", 16'(full), 16'(e.full));
        chk("sb_busy", 16'(busy), 16'(e.busy));
        chk("sb_entered", 16'(entered), 16'(e.entered));
        chk("sb_entered_value", entered_value, e.entered_value);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'h0, 1'b0);
    endtask

    task automatic press(input logic [3:0] k);
        step(k, 1'b1);
        idle(5);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        key         = 4'h0;
        key_pressed = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 16'h0);
        chk("rst_count", 16'(count), 16'h0);
        chk("rst_flags", 16'({full, busy, entered}), 16'h0);
        chk("rst_entered_value", entered_value, 16'h0);
        rst_n = 1'b1;
        idle(3);

        // Digit sequence with busy tracked every cycle by the scoreboard
        step(4'h1, 1'b1); chk("d1_busy", 16'(busy), 16'h1); idle(6);
        step(4'h2, 1'b1); idle(6);
        step(4'h3, 1'b1); idle(6);
        chk("seq_value", value, 16'h0123);
        chk("seq_count", 16'(count), 16'h3);
        press(4'hC);

        // Second press inside lockout is dropped
        step(4'h5, 1'b1); idle(1); step(4'h7, 1'b1); idle(5);
        chk("filter_value", value, 16'h0005);
        chk("filter_count", 16'(count), 16'h1);
        press(4'hC);

        // Overflow keeps the first four digits
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h9);
        chk("ovf_value", value, 16'h1234);
        chk("ovf_count", 16'(count), 16'h4);
        chk("ovf_full", 16'(full), 16'h1);
        press(4'hC);

        // Backspace then enter
        press(4'h1); press(4'h2); press(4'h3);
        press(4'hD);
        chk("bs_value", value, 16'h0012);
        step(4'hE, 1'b1);
        chk("ent_pulse", 16'(entered), 16'h1);
        chk("ent_captured", entered_value, 16'h0012);
        idle(1);
        chk("ent_pulse_end", 16'(entered), 16'h0);
        chk("ent_value_clr", value, 16'h0);
        chk("ent_count_clr", 16'(count), 16'h0);
        idle(4);

        // Empty enter starts lockout without a pulse; A is a pure no-op
        step(4'hE, 1'b1);
        chk("empty_ent_busy", 16'(busy), 16'h1);
        chk("empty_ent_pulse", 16'(entered), 16'h0);
        idle(5);
        step(4'hA, 1'b1);
        chk("noop_busy", 16'(busy), 16'h0);
        chk("noop_entered_value", entered_value, 16'h0012);
        idle(2);

        // Reset in the middle of a lockout
        step(4'h6, 1'b1); idle(2);
        chk("pre_rst_busy", 16'(busy), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_value", value, 16'h0);
        chk("mid_rst_flags", 16'({full, busy, entered, count}), 16'h0);
        chk("mid_rst_entered_value", entered_value, 16'h0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        press(4'h8);
        chk("post_rst_value", value, 16'h0008);
        chk("post_rst_count", 16'(count), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
